sys_mem_arb: RTL and testbench
==============================

SYS_MEM_ARB -- requirements
Module: sys_mem_arb

Interface
REQ-001 The block SHALL have the following parameters, one per line: name, default, meaning.
- SYS_MEM_DATA_W, 32, system memory data width.
- SYS_MEM_ADDR_W, 27, system memory address width.
- MAX_OUTSTD, 8, maximum number of outstanding reads; power of 2.
- P0_BURST_MAX, 16, maximum consecutive port-0 grants while port 1 is waiting.

REQ-002 The block SHALL have the following ports, one per line: name, direction, width, meaning.
- clk, in, 1, single clock.
- rst_n, in, 1, reset; asynchronous, active-low.
- mN_wait, out, 1, stall to requester N (N = 0 video line-buffer fetch, N = 1 graphics/CPU).
- mN_wren, in, 1, write request from requester N.
- mN_rden, in, 1, read request from requester N.
- mN_addr, in, SYS_MEM_ADDR_W, address from requester N.
- mN_wdata, in, SYS_MEM_DATA_W, write data from requester N.
- mN_rd_valid, out, 1, read-data strobe routed to requester N.
- mN_rdata, out, SYS_MEM_DATA_W, read data to requester N.
- sys_mem_wait, in, 1, stall from the memory slave.
- sys_mem_wren, out, 1, write to the memory slave.
- sys_mem_rden, out, 1, read to the memory slave.
- sys_mem_addr, out, SYS_MEM_ADDR_W, address to the memory slave.
- sys_mem_wdata, out, SYS_MEM_DATA_W, write data to the memory slave.
- sys_mem_rd_valid, in, 1, read data strobe from the memory slave.
- sys_mem_rdata, in, SYS_MEM_DATA_W, read data from the memory slave.
- rsp_err, out, 1, sticky flag: rd_valid arrived with the tag FIFO empty.

Function
REQ-003 Requests: reqN = mN_wren | mN_rden; wren and rden are never both high (requester rule).
REQ-004 State machine states: ARB_IDLE, ARB_P0, ARB_P1.
- ARB_IDLE: no lock held.
- ARB_Px: a port-x command was presented and stalled last cycle; that port is locked.
REQ-005 Owner selection:
- When locked, owner = the locked port.
- Otherwise port 1 is owner if req1 & (~req0 | burst_cnt == P0_BURST_MAX); else port 0 is owner if req0; else no owner.
REQ-006 Blocking: blk = owner read & tag FIFO full.
REQ-007 Slave outputs: sys_mem_addr/wdata SHALL be the owner's signals with zero latency; sys_mem_wren/rden SHALL be the owner's strobes gated by ~blk; all outputs SHALL be 0 with no owner.
REQ-008 Stalls: mN_wait = ~(owner == N) | sys_mem_wait | blk; a non-owner with a request SHALL see wait = 1.
REQ-009 Accept and lock:
- accept = owner strobe & ~sys_mem_wait & ~blk.
- Next state = ARB_Px when owner x has a request and is not accepted; else ARB_IDLE.
REQ-010 burst_cnt, width clog2(P0_BURST_MAX+1):
- Increments on a port-0 accept while req1.
- Clears on a port-1 accept, or when ~req1.
- Saturates at P0_BURST_MAX.
REQ-011 Tag FIFO, MAX_OUTSTD entries of 1 bit:
- Each accepted read SHALL push the owner ID.
- Each sys_mem_rd_valid SHALL pop one entry.
- Push and pop in the same cycle SHALL leave the count unchanged.
REQ-012 Read response routing:
- mN_rd_valid = sys_mem_rd_valid & FIFO not empty & head == N, zero latency.
- m0_rdata = m1_rdata = sys_mem_rdata.
REQ-013 rd_valid with the FIFO empty: no pop, no mN_rd_valid, and rsp_err SHALL be set and held until reset.
REQ-014 Responses SHALL be delivered in issue order; writes SHALL never push a tag.

Reset
REQ-015 While rst_n = 0 (asynchronous assertion):
- state = ARB_IDLE, burst_cnt = 0, tag FIFO empty, rsp_err = 0.
- All sys_mem_* strobes, mN_rd_valid = 0; mN_wait = 1 while reqN (no owner possible during reset).
REQ-016 Reset mid-operation SHALL discard outstanding tags; responses arriving after reset SHALL raise rsp_err.

Structure
REQ-017 Package sys_mem_arb_pkg SHALL hold the state enum (ARB_IDLE/ARB_P0/ARB_P1), the port-ID typedef (P0 = 0, P1 = 1) and the default widths.
REQ-018 The tag FIFO SHALL be the sub-module sys_mem_arb_tag_ff: synchronous, 1-bit wide, MAX_OUTSTD deep, with full, empty and a count output.

Verification
REQ-019 Single reads: m0 reads addr 0x10, then m1 reads 0x20, no wait; slave returns 0xA, 0xB -> m0_rd_valid with 0xA, then m1_rd_valid with 0xB; no cross-delivery.
REQ-020 Starvation guard: req0 and req1 held continuously, P0_BURST_MAX = 16 -> 16 port-0 accepts, 1 port-1 accept, repeating.
REQ-021 Lock: m1 write presented while sys_mem_wait = 1 for 5 cycles, m0 requesting meanwhile -> sys_mem_addr stays at the m1 address, m0_wait = 1 throughout, m1 accepted on cycle 6.
REQ-022 Outstanding limit: 8 reads issued with no responses -> 9th read sees m0_wait = 1 and sys_mem_rden = 0; one rd_valid -> 9th read accepted in the same cycle as the pop.
REQ-023 Error and reset: rd_valid with FIFO empty -> rsp_err = 1 and stays set; mid-traffic rst_n pulse -> all outputs at reset values and FIFO empty.

Source files
------------

// File: rtl/sys_mem_arb_pkg.sv
// sys_mem_arb shared types and defaults.
// State, port ID and default geometry for the arbiter.
package sys_mem_arb_pkg;

  localparam int DEF_DATA_W     = 32;
  localparam int DEF_ADDR_W     = 27;
  localparam int DEF_MAX_OUTSTD = 8;
  localparam int DEF_BURST_MAX  = 16;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_P0   = 2'd1,
    ARB_P1   = 2'd2
  } arb_state_t;

  typedef enum logic {
    P0 = 1'b0,
    P1 = 1'b1
  } port_id_t;

endpackage

// File: rtl/sys_mem_arb_tag_ff.sv
// sys_mem_arb read-tag FIFO.
// Holds the issuing port ID of each outstanding read, oldest at head.
module sys_mem_arb_tag_ff #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic                     i_din,
  input  logic                     i_pop,
  output logic                     o_head,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic          r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_cnt;
  logic          w_do_push;
  logic          w_do_pop;

  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  assign o_full  = (r_cnt == FULL_CNT);
  assign o_empty = (r_cnt == '0);
  assign o_count = r_cnt;
  assign o_head  = r_mem[r_rptr];

  // Storage write; contents are don't-care until pushed.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr] <= i_din;
  end

  // Pointer and occupancy tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + AW'(1);
      if (w_do_pop)  r_rptr <= r_rptr + AW'(1);
      unique case ({w_do_push, w_do_pop})
        2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
        2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/sys_mem_arb.sv
// sys_mem_arb: two-port system memory arbiter.
// Port 0 is favoured, port 1 guarded against starvation; reads routed by tag.
module sys_mem_arb
  import sys_mem_arb_pkg::*;
#(
  parameter int SYS_MEM_DATA_W = DEF_DATA_W,
  parameter int SYS_MEM_ADDR_W = DEF_ADDR_W,
  parameter int MAX_OUTSTD     = DEF_MAX_OUTSTD,
  parameter int P0_BURST_MAX   = DEF_BURST_MAX
) (
  input  logic                      clk,
  input  logic                      rst_n,
  output logic                      m0_wait,
  input  logic                      m0_wren,
  input  logic                      m0_rden,
  input  logic [SYS_MEM_ADDR_W-1:0] m0_addr,
  input  logic [SYS_MEM_DATA_W-1:0] m0_wdata,
  output logic                      m0_rd_valid,
  output logic [SYS_MEM_DATA_W-1:0] m0_rdata,
  output logic                      m1_wait,
  input  logic                      m1_wren,
  input  logic                      m1_rden,
  input  logic [SYS_MEM_ADDR_W-1:0] m1_addr,
  input  logic [SYS_MEM_DATA_W-1:0] m1_wdata,
  output logic                      m1_rd_valid,
  output logic [SYS_MEM_DATA_W-1:0] m1_rdata,
  input  logic                      sys_mem_wait,
  output logic                      sys_mem_wren,
  output logic                      sys_mem_rden,
  output logic [SYS_MEM_ADDR_W-1:0] sys_mem_addr,
  output logic [SYS_MEM_DATA_W-1:0] sys_mem_wdata,
  input  logic                      sys_mem_rd_valid,
  input  logic [SYS_MEM_DATA_W-1:0] sys_mem_rdata,
  output logic                      rsp_err
);

  localparam int CW = $clog2(P0_BURST_MAX + 1);
  localparam logic [CW-1:0] BURST_MAX = CW'(P0_BURST_MAX);
  localparam int TW = $clog2(MAX_OUTSTD) + 1;

  arb_state_t r_state;
  logic [CW-1:0] r_burst;
  logic          r_err;

  logic w_req0;
  logic w_req1;
  logic w_own_vld;
  port_id_t w_own;
  logic w_own_wr;
  logic w_own_rd;
  logic [SYS_MEM_ADDR_W-1:0] w_own_addr;
  logic [SYS_MEM_DATA_W-1:0] w_own_wdata;
  logic w_blk;
  logic w_accept;
  logic w_push;
  logic w_pop;
  logic w_head;
  logic w_full;
  logic w_empty;
  logic [TW-1:0] w_count;

  assign w_req0 = m0_wren | m0_rden;
  assign w_req1 = m1_wren | m1_rden;

  // Owner selection: lock wins, then starvation guard, then port 0.
  always_comb begin
    w_own_vld = 1'b0;
    w_own     = P0;
    if (rst_n) begin
      unique case (r_state)
        ARB_P0: begin
          w_own_vld = 1'b1;
          w_own     = P0;
        end
        ARB_P1: begin
          w_own_vld = 1'b1;
          w_own     = P1;
        end
        default: begin
          if (w_req1 & (~w_req0 | (r_burst == BURST_MAX))) begin
            w_own_vld = 1'b1;
            w_own     = P1;
          end else if (w_req0) begin
            w_own_vld = 1'b1;
            w_own     = P0;
          end
        end
      endcase
    end
  end

  // Owner command mux; all zero when nobody owns the slave.
  always_comb begin
    w_own_wr    = 1'b0;
    w_own_rd    = 1'b0;
    w_own_addr  = '0;
    w_own_wdata = '0;
    if (w_own_vld) begin
      if (w_own == P1) begin
        w_own_wr    = m1_wren;
        w_own_rd    = m1_rden;
        w_own_addr  = m1_addr;
        w_own_wdata = m1_wdata;
      end else begin
        w_own_wr    = m0_wren;
        w_own_rd    = m0_rden;
        w_own_addr  = m0_addr;
        w_own_wdata = m0_wdata;
      end
    end
  end

  // A pop in the same cycle frees a slot, so a full FIFO does not block then.
  assign w_pop    = sys_mem_rd_valid & ~w_empty;
  assign w_blk    = w_own_rd & w_full & ~w_pop;
  assign w_accept = (w_own_wr | w_own_rd) & ~sys_mem_wait & ~w_blk;
  assign w_push   = w_accept & w_own_rd;

  assign sys_mem_wren  = w_own_wr & ~w_blk;
  assign sys_mem_rden  = w_own_rd & ~w_blk;
  assign sys_mem_addr  = w_own_addr;
  assign sys_mem_wdata = w_own_wdata;

  assign m0_wait = ~(w_own_vld & (w_own == P0)) | sys_mem_wait | w_blk;
  assign m1_wait = ~(w_own_vld & (w_own == P1)) | sys_mem_wait | w_blk;

  assign m0_rd_valid = w_pop & ~w_head;
  assign m1_rd_valid = w_pop & w_head;
  assign m0_rdata    = sys_mem_rdata;
  assign m1_rdata    = sys_mem_rdata;
  assign rsp_err     = r_err;

  // Lock FSM: hold the owner whose command stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ARB_IDLE;
    end else if (w_own_vld & (w_own_wr | w_own_rd) & ~w_accept) begin
      r_state <= (w_own == P1) ? ARB_P1 : ARB_P0;
    end else begin
      r_state <= ARB_IDLE;
    end
  end

  // Consecutive port-0 grants while port 1 waits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_burst <= '0;
    end else if (~w_req1) begin
      r_burst <= '0;
    end else if (w_accept & (w_own == P1)) begin
      r_burst <= '0;
    end else if (w_accept & (r_burst != BURST_MAX)) begin
      r_burst <= r_burst + CW'(1);
    end
  end

  // Sticky error: response with no outstanding read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (sys_mem_rd_valid & (w_count == '0)) begin
      r_err <= 1'b1;
    end
  end

  sys_mem_arb_tag_ff #(
    .DEPTH (MAX_OUTSTD)
  ) u_tag_ff (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_din   (w_own == P1),
    .i_pop   (sys_mem_rd_valid),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

endmodule

// File: tb/tb_sys_mem_arb.sv
// tb_sys_mem_arb: scenario bench for the two-port memory arbiter.
// Read tags are queued at issue and checked by a response monitor.
module tb_sys_mem_arb;

  localparam int DW = 32;
  localparam int AW = 27;

  logic          clk;
  logic          rst_n;
  logic          m0_wait, m1_wait;
  logic          m0_wren, m0_rden, m1_wren, m1_rden;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata;
  logic          m0_rd_valid, m1_rd_valid;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          sys_mem_wait;
  logic          sys_mem_wren, sys_mem_rden;
  logic [AW-1:0] sys_mem_addr;
  logic [DW-1:0] sys_mem_wdata;
  logic          sys_mem_rd_valid;
  logic [DW-1:0] sys_mem_rdata;
  logic          rsp_err;

  int n_tests = 0;
  int n_fail  = 0;
  bit q_port[$];
  logic [DW-1:0] rsp_data;

  sys_mem_arb #(
    .SYS_MEM_DATA_W (DW),
    .SYS_MEM_ADDR_W (AW),
    .MAX_OUTSTD     (8),
    .P0_BURST_MAX   (16)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .m0_wait          (m0_wait),
    .m0_wren          (m0_wren),
    .m0_rden          (m0_rden),
    .m0_addr          (m0_addr),
    .m0_wdata         (m0_wdata),
    .m0_rd_valid      (m0_rd_valid),
    .m0_rdata         (m0_rdata),
    .m1_wait          (m1_wait),
    .m1_wren          (m1_wren),
    .m1_rden          (m1_rden),
    .m1_addr          (m1_addr),
    .m1_wdata         (m1_wdata),
    .m1_rd_valid      (m1_rd_valid),
    .m1_rdata         (m1_rdata),
    .sys_mem_wait     (sys_mem_wait),
    .sys_mem_wren     (sys_mem_wren),
    .sys_mem_rden     (sys_mem_rden),
    .sys_mem_addr     (sys_mem_addr),
    .sys_mem_wdata    (sys_mem_wdata),
    .sys_mem_rd_valid (sys_mem_rd_valid),
    .sys_mem_rdata    (sys_mem_rdata),
    .rsp_err          (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Response scoreboard: each slave strobe must reach the oldest issuer.
  always @(negedge clk) begin
    if (rst_n && sys_mem_rd_valid) begin
      n_tests++;
      if (q_port.size() > 0) begin
        automatic bit p = q_port.pop_front();
        automatic logic [1:0] exp_v = p ? 2'b10 : 2'b01;
        automatic logic [DW-1:0] got_d = p ? m1_rdata : m0_rdata;
        if ({m1_rd_valid, m0_rd_valid} !== exp_v || got_d !== rsp_data) begin
          n_fail++;
          $display("FAIL rsp_route got v=%b d=%h want v=%b d=%h",
                   {m1_rd_valid, m0_rd_valid}, got_d, exp_v, rsp_data);
        end
      end else begin
        if ({m1_rd_valid, m0_rd_valid} !== 2'b00) begin
          n_fail++;
          $display("FAIL rsp_orphan got v=%b want 00",
                   {m1_rd_valid, m0_rd_valid});
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    m0_rden = 1'b1;
    m0_addr = 27'h44;
    #2;
    n_tests++;
    if (m0_wait !== 1'b1 || sys_mem_rden !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_stall got wait=%b rden=%b want 1 0", m0_wait, sys_mem_rden);
    end
    n_tests++;
    if (rsp_err !== 1'b0 || m0_rd_valid !== 1'b0 || m1_rd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags got err=%b v=%b%b want 0 00",
               rsp_err, m1_rd_valid, m0_rd_valid);
    end
    step();
    step();
    m0_rden = 1'b0;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single_reads();
    m0_rden = 1'b1;
    m0_addr = 27'h10;
    #1;
    n_tests++;
    if (m0_wait !== 1'b0 || sys_mem_rden !== 1'b1 || sys_mem_addr !== 27'h10) begin
      n_fail++;
      $display("FAIL rd0_issue got w=%b r=%b a=%h want 0 1 10",
               m0_wait, sys_mem_rden, sys_mem_addr);
    end
    q_port.push_back(1'b0);
    step();
    m0_rden = 1'b0;
    m1_rden = 1'b1;
    m1_addr = 27'h20;
    #1;
    n_tests++;
    if (m1_wait !== 1'b0 || sys_mem_rden !== 1'b1 || sys_mem_addr !== 27'h20) begin
      n_fail++;
      $display("FAIL rd1_issue got w=%b r=%b a=%h want 0 1 20",
               m1_wait, sys_mem_rden, sys_mem_addr);
    end
    q_port.push_back(1'b1);
    step();
    m1_rden = 1'b0;
    sys_mem_rd_valid = 1'b1;
    rsp_data = 32'hA;
    sys_mem_rdata = rsp_data;
    step();
    rsp_data = 32'hB;
    sys_mem_rdata = rsp_data;
    step();
    sys_mem_rd_valid = 1'b0;
    n_tests++;
    if (q_port.size() !== 0) begin
      n_fail++;
      $display("FAIL rd_drain got left=%0d want 0", q_port.size());
    end
    step();
  endtask

  task automatic test_starvation();
    m0_wren = 1'b1;
    m1_wren = 1'b1;
    m0_addr = 27'h100;
    m1_addr = 27'h200;
    for (int k = 0; k < 34; k++) begin
      automatic logic [1:0] exp_w = ((k % 17) == 16) ? 2'b01 : 2'b10;
      #1;
      n_tests++;
      if ({m1_wait, m0_wait} !== exp_w || sys_mem_wren !== 1'b1) begin
        n_fail++;
        $display("FAIL starve_k%0d got w1w0=%b wr=%b want %b 1",
                 k, {m1_wait, m0_wait}, sys_mem_wren, exp_w);
      end
      step();
    end
    m0_wren = 1'b0;
    m1_wren = 1'b0;
    step();
  endtask

  task automatic test_lock();
    sys_mem_wait = 1'b1;
    m1_wren = 1'b1;
    m1_addr = 27'h55;
    m1_wdata = 32'hCAFE;
    #1;
    n_tests++;
    if (sys_mem_addr !== 27'h55 || m1_wait !== 1'b1) begin
      n_fail++;
      $display("FAIL lock_c0 got a=%h w1=%b want 55 1", sys_mem_addr, m1_wait);
    end
    for (int c = 1; c < 5; c++) begin
      step();
      m0_rden = 1'b1;
      m0_addr = 27'h66;
      #1;
      n_tests++;
      if (sys_mem_addr !== 27'h55 || m0_wait !== 1'b1 || sys_mem_wren !== 1'b1) begin
        n_fail++;
        $display("FAIL lock_c%0d got a=%h w0=%b wr=%b want 55 1 1",
                 c, sys_mem_addr, m0_wait, sys_mem_wren);
      end
    end
    step();
    sys_mem_wait = 1'b0;
    #1;
    n_tests++;
    if (m1_wait !== 1'b0 || m0_wait !== 1'b1 || sys_mem_addr !== 27'h55 ||
        sys_mem_wdata !== 32'hCAFE) begin
      n_fail++;
      $display("FAIL lock_accept got w1=%b w0=%b a=%h d=%h want 0 1 55 cafe",
               m1_wait, m0_wait, sys_mem_addr, sys_mem_wdata);
    end
    step();
    m1_wren = 1'b0;
    #1;
    n_tests++;
    if (m0_wait !== 1'b0 || sys_mem_rden !== 1'b1 || sys_mem_addr !== 27'h66) begin
      n_fail++;
      $display("FAIL lock_next got w0=%b r=%b a=%h want 0 1 66",
               m0_wait, sys_mem_rden, sys_mem_addr);
    end
    q_port.push_back(1'b0);
    step();
    m0_rden = 1'b0;
    sys_mem_rd_valid = 1'b1;
    rsp_data = 32'hC;
    sys_mem_rdata = rsp_data;
    step();
    sys_mem_rd_valid = 1'b0;
    step();
  endtask

  task automatic test_outstanding();
    for (int i = 0; i < 8; i++) begin
      m0_rden = 1'b1;
      m0_addr = AW'(i);
      #1;
      n_tests++;
      if (m0_wait !== 1'b0 || sys_mem_rden !== 1'b1) begin
        n_fail++;
        $display("FAIL outstd_rd%0d got w=%b r=%b want 0 1", i, m0_wait, sys_mem_rden);
      end
      q_port.push_back(1'b0);
      step();
    end
    m0_addr = 27'h99;
    #1;
    n_tests++;
    if (m0_wait !== 1'b1 || sys_mem_rden !== 1'b0) begin
      n_fail++;
      $display("FAIL outstd_full got w=%b r=%b want 1 0", m0_wait, sys_mem_rden);
    end
    step();
    sys_mem_rd_valid = 1'b1;
    rsp_data = 32'h100;
    sys_mem_rdata = rsp_data;
    #1;
    n_tests++;
    if (m0_wait !== 1'b0 || sys_mem_rden !== 1'b1 || sys_mem_addr !== 27'h99) begin
      n_fail++;
      $display("FAIL outstd_pop got w=%b r=%b a=%h want 0 1 99",
               m0_wait, sys_mem_rden, sys_mem_addr);
    end
    q_port.push_back(1'b0);
    step();
    m0_rden = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rsp_data = 32'h200 + DW'(i);
      sys_mem_rdata = rsp_data;
      step();
    end
    sys_mem_rd_valid = 1'b0;
    n_tests++;
    if (q_port.size() !== 0 || rsp_err !== 1'b0) begin
      n_fail++;
      $display("FAIL outstd_drain got left=%0d err=%b want 0 0", q_port.size(), rsp_err);
    end
    step();
  endtask

  task automatic test_error_reset();
    sys_mem_rd_valid = 1'b1;
    rsp_data = 32'hDEAD;
    sys_mem_rdata = rsp_data;
    step();
    sys_mem_rd_valid = 1'b0;
    n_tests++;
    if (rsp_err !== 1'b1) begin
      n_fail++;
      $display("FAIL err_set got %b want 1", rsp_err);
    end
    repeat (3) step();
    n_tests++;
    if (rsp_err !== 1'b1) begin
      n_fail++;
      $display("FAIL err_sticky got %b want 1", rsp_err);
    end
    m0_rden = 1'b1;
    m0_addr = 27'h300;
    q_port.push_back(1'b0);
    step();
    q_port.push_back(1'b0);
    step();
    #2;
    rst_n = 1'b0;
    q_port.delete();
    #1;
    n_tests++;
    if (m0_wait !== 1'b1 || sys_mem_rden !== 1'b0 || rsp_err !== 1'b0 ||
        m0_rd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid got w=%b r=%b err=%b v=%b want 1 0 0 0",
               m0_wait, sys_mem_rden, rsp_err, m0_rd_valid);
    end
    step();
    m0_rden = 1'b0;
    rst_n = 1'b1;
    step();
    n_tests++;
    if (rsp_err !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_err_clr got %b want 0", rsp_err);
    end
    sys_mem_rd_valid = 1'b1;
    rsp_data = 32'hBEEF;
    sys_mem_rdata = rsp_data;
    step();
    sys_mem_rd_valid = 1'b0;
    n_tests++;
    if (rsp_err !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_stale_rsp got err=%b want 1", rsp_err);
    end
    step();
  endtask

  initial begin
    m0_wren = 1'b0;
    m0_rden = 1'b0;
    m1_wren = 1'b0;
    m1_rden = 1'b0;
    m0_addr = '0;
    m1_addr = '0;
    m0_wdata = '0;
    m1_wdata = '0;
    sys_mem_wait = 1'b0;
    sys_mem_rd_valid = 1'b0;
    sys_mem_rdata = '0;
    rsp_data = '0;
    test_reset();
    test_single_reads();
    test_starvation();
    test_lock();
    test_outstanding();
    test_error_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
